spi_slave_port: RTL and testbench
=================================

// Module: spi_slave_port
// PURPOSE
//  Synthesizable SPI responder: the far end of the 8-bit-lane SPI link driven by our SPI master.
//  Oversamples SCLK/CS/MOSI on the local clock and supports all four CPOL/CPHA modes.
//  Each SCLK period moves one LANE_W-bit beat in each direction.
//  Presents received beats and accepts transmit beats via valid/ready handshakes to local logic.
// PARAMETERS
//  LANE_W   8     bits transferred per SCLK period (MOSI/MISO width)
//  FILL     8'h00 MISO value driven when no transmit beat is available (underrun)
// PORTS
//  clk          in   1       local clock; must be >= 8x SCLK frequency
//  rst          in   1       synchronous reset, active-high
//  SCLK         in   1       serial clock from master (asynchronous to clk)
//  CS           in   1       chip select, active-low (one of master CS1..CS3)
//  MOSI         in   LANE_W  master-to-slave beat
//  cpol         in   1       clock polarity; sampled only while CS high
//  cpha         in   1       clock phase; sampled only while CS high
//  MISO         out  LANE_W  slave-to-master beat
//  MISO_oe      out  1       MISO output enable (1 while frame active)
//  rx_data      out  LANE_W  received beat
//  rx_valid     out  1       rx_data holds an unread beat
//  rx_ready     in   1       local logic consumes rx_data when rx_valid&rx_ready
//  tx_data      in   LANE_W  beat to return on MISO
//  tx_valid     in   1       tx_data offered
//  tx_ready     out  1       1 = tx holding register empty; accept on tx_valid&tx_ready
//  rx_overflow  out  1       1-clk pulse: beat dropped, rx holding register full
//  tx_underrun  out  1       1-clk pulse: FILL driven, no tx beat held
//  frame_done   out  1       1-clk pulse on CS deassert ending an active frame
//  frame_beats  out  8       beats received in last frame (saturates at 255); valid at frame_done
// BEHAVIOUR
//  Reset: MISO=FILL, MISO_oe=0, rx_valid=0, rx_data=0, tx_ready=1, pulses=0, frame_beats=0,
//   state=IDLE, mode reg={0,0}, tx holding empty.
//  Input sync: SCLK, CS, MOSI pass 2 flops; edges detected on the 3rd stage vs. 2nd -> action occurs
//   3 clk after the pin edge. MOSI is sampled from the same synchronized stage as SCLK.
//  Mode reg {cpol,cpha} loads every clk while synced CS=1; frozen while CS=0.
//  Sample edge: rising for modes 0 and 3; falling for modes 1 and 2. Shift edge is the opposite edge.
//  FSM:
//   WAIT_IDLE: entered from rst. Goes to IDLE only after synced CS=1, so a frame in progress at reset is ignored.
//   IDLE: on CS fall -> ACTIVE. MISO_oe=1 and beat counter cleared.
//    If cpha=0, perform a load on this clk.
//   ACTIVE: on each sample edge, capture MOSI and increment beat counter (saturating at 255).
//    On each shift edge, perform a load, except the first shift edge when cpha=0.
//    On CS rise -> IDLE: MISO_oe=0, frame_done=1, frame_beats=counter.
//  Load: if tx held, MISO<=tx hold and hold emptied (tx_ready=1 next clk).
//   Otherwise MISO<=FILL and tx_underrun=1.
//  Capture: if rx_valid=0, or rx_valid&rx_ready in the same clk, rx_data<=MOSI and rx_valid=1.
//   Otherwise the beat is dropped, rx_overflow=1, and rx_data is unchanged.
//  rx_valid clears on rx_valid&rx_ready with no capture in that clk.
//  tx accept: tx_valid&tx_ready stores tx_data and sets tx_ready=0 next clk.
//   Accept and load in the same clk: the load uses the old content (FILL if empty); the new beat is held for the next load.
//  CS rise mid-beat (before the sample edge): partial beat discarded, counter not incremented.
//  SCLK edges while CS=1 are ignored; MISO holds its last value with MISO_oe=0.
//  rst during ACTIVE: immediate reset values, WAIT_IDLE, no frame_done.
// TESTING
//  Mode0, tx preloaded A5, master sends 3C,81 -> rx beats 3C then 81.
//   MISO=A5 from CS fall, then 00 with one tx_underrun; frame_done with frame_beats=2.
//  Mode3, tx feeds 5A,C3 on demand, master sends 01,02 -> MISO 5A,C3; rx 01,02; no flags.
//  Mode1 then mode2 (cpol/cpha changed while CS high), each sends F0 ->
//   rx F0 both frames; toggling cpol while CS low has no effect.
//  rx_ready=0, master sends 11,22,33 -> rx_data stays 11; rx_overflow pulses twice.
//  rx_ready=1 in the same clk as a capture (rx_valid=1) -> new beat stored, no overflow.
//  rst asserted after beat 1 of a 3-beat frame -> outputs at reset values, no rx_valid, no frame_done.
//   Next full frame 44 -> frame_beats=1.

Source files
------------

// File: rtl/spi_slave_port_if.sv
// Pin-level SPI lanes plus the local rx/tx valid/ready beat handshakes of spi_slave_port.
// slave = the responder's view, master = the view of whatever drives the link and local logic.
interface spi_slave_port_if #(
    parameter int unsigned LANE_W = 8
);
    logic              SCLK;
    logic              CS;
    logic [LANE_W-1:0] MOSI;
    logic              cpol;
    logic              cpha;
    logic [LANE_W-1:0] MISO;
    logic              MISO_oe;
    logic [LANE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [LANE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              rx_overflow;
    logic              tx_underrun;
    logic              frame_done;
    logic [7:0]        frame_beats;

    modport slave (
        input  SCLK, CS, MOSI, cpol, cpha, rx_ready, tx_data, tx_valid,
        output MISO, MISO_oe, rx_data, rx_valid, tx_ready,
               rx_overflow, tx_underrun, frame_done, frame_beats
    );

    modport master (
        output SCLK, CS, MOSI, cpol, cpha, rx_ready, tx_data, tx_valid,
        input  MISO, MISO_oe, rx_data, rx_valid, tx_ready,
               rx_overflow, tx_underrun, frame_done, frame_beats
    );
endinterface

// File: rtl/spi_slave_port.sv
// SPI responder: oversamples SCLK/CS/MOSI on clk, all four CPOL/CPHA modes, one LANE_W beat per SCLK period.
// Actions land 3 clk after a pin edge; rx/tx use single-entry holding registers with valid/ready.
module spi_slave_port #(
    parameter int unsigned       LANE_W = 8,
    parameter logic [LANE_W-1:0] FILL   = '0
) (
    input  logic            clk,
    input  logic            rst,
    spi_slave_port_if.slave bus
);
    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

    logic [2:0]        sclk_q, cs_q;
    logic [LANE_W-1:0] mosi1_q, mosi2_q;

    state_t            state_q, state_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d;
    logic              skip_q, skip_d;
    logic [7:0]        count_q, count_d, frame_beats_q, frame_beats_d;
    logic [LANE_W-1:0] miso_q, miso_d, rx_data_q, rx_data_d, hold_q, hold_d;
    logic              oe_q, oe_d, rx_valid_q, rx_valid_d, full_q, full_d;
    logic              ovf_q, ovf_d, und_q, und_d, done_q, done_d;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_lvl;
    logic sample_on_rise, sample_edge, shift_edge;
    logic do_load, do_capture, tx_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q  <= '0;
            cs_q    <= '0;
            mosi1_q <= '0;
            mosi2_q <= '0;
        end else begin
            sclk_q  <= {sclk_q[1:0], bus.SCLK};
            cs_q    <= {cs_q[1:0], bus.CS};
            mosi1_q <= bus.MOSI;
            mosi2_q <= mosi1_q;
        end
    end

    // MOSI is taken from the same stage as the SCLK level that reveals the edge.
    assign sclk_rise      =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall      = ~sclk_q[1] &  sclk_q[2];
    assign cs_rise        =  cs_q[1] & ~cs_q[2];
    assign cs_fall        = ~cs_q[1] &  cs_q[2];
    assign cs_lvl         =  cs_q[1];
    assign sample_on_rise = (cpol_q == cpha_q);
    assign sample_edge    = sample_on_rise ? sclk_rise : sclk_fall;
    assign shift_edge     = sample_on_rise ? sclk_fall : sclk_rise;
    assign tx_accept      = bus.tx_valid & ~full_q;

    always_comb begin
        state_d       = state_q;
        cpol_d        = cpol_q;
        cpha_d        = cpha_q;
        skip_d        = skip_q;
        count_d       = count_q;
        frame_beats_d = frame_beats_q;
        miso_d        = miso_q;
        rx_data_d     = rx_data_q;
        hold_d        = hold_q;
        oe_d          = oe_q;
        rx_valid_d    = rx_valid_q;
        full_d        = full_q;
        ovf_d         = 1'b0;
        und_d         = 1'b0;
        done_d        = 1'b0;
        do_load       = 1'b0;
        do_capture    = 1'b0;

        if (cs_lvl) begin
            cpol_d = bus.cpol;
            cpha_d = bus.cpha;
        end

        case (state_q)
            WAIT_IDLE: begin
                if (cs_lvl) state_d = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    oe_d    = 1'b1;
                    count_d = '0;
                    skip_d  = ~cpha_q;
                    do_load = ~cpha_q;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d       = IDLE;
                    oe_d          = 1'b0;
                    done_d        = 1'b1;
                    frame_beats_d = count_q;
                end else begin
                    if (sample_edge) begin
                        do_capture = 1'b1;
                        if (count_q != 8'hFF) count_d = count_q + 8'd1;
                    end
                    // With cpha=0 the first beat was loaded at CS fall, so its shift edge is spent.
                    if (shift_edge) begin
                        if (skip_q) skip_d  = 1'b0;
                        else        do_load = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase

        if (do_load) begin
            if (full_q) begin
                miso_d = hold_q;
                full_d = 1'b0;
            end else begin
                miso_d = FILL;
                und_d  = 1'b1;
            end
        end
        if (tx_accept) begin
            hold_d = bus.tx_data;
            full_d = 1'b1;
        end

        if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;
        if (do_capture) begin
            if (!rx_valid_q || bus.rx_ready) begin
                rx_data_d  = mosi2_q;
                rx_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_IDLE;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            skip_q        <= 1'b0;
            count_q       <= '0;
            frame_beats_q <= '0;
            miso_q        <= FILL;
            rx_data_q     <= '0;
            hold_q        <= '0;
            oe_q          <= 1'b0;
            rx_valid_q    <= 1'b0;
            full_q        <= 1'b0;
            ovf_q         <= 1'b0;
            und_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cpol_q        <= cpol_d;
            cpha_q        <= cpha_d;
            skip_q        <= skip_d;
            count_q       <= count_d;
            frame_beats_q <= frame_beats_d;
            miso_q        <= miso_d;
            rx_data_q     <= rx_data_d;
            hold_q        <= hold_d;
            oe_q          <= oe_d;
            rx_valid_q    <= rx_valid_d;
            full_q        <= full_d;
            ovf_q         <= ovf_d;
            und_q         <= und_d;
            done_q        <= done_d;
        end
    end

    assign bus.MISO        = miso_q;
    assign bus.MISO_oe     = oe_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_ready    = ~full_q;
    assign bus.rx_overflow = ovf_q;
    assign bus.tx_underrun = und_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_beats = frame_beats_q;
endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: drives SPI frames as the master and checks against a beat-level model.
module tb_spi_slave_port;
    localparam int unsigned LW    = 8;
    localparam logic [7:0]  FILLV = 8'h00;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_port_if #(.LANE_W(LW)) bus ();
    spi_slave_port #(.LANE_W(LW), .FILL(FILLV)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    logic [7:0] txq[$];
    logic [7:0] mtx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_fb[$];
    logic [7:0] got_miso[$];
    int  exp_und = 0, exp_ovf = 0, cnt_und = 0, cnt_ovf = 0;
    bit  m_slot_full = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Half SCLK period of 8 clk; optionally raises rx_ready only in the clk the beat is captured.
    task automatic half(input bit pr);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (pr && k == 2) bus.rx_ready = 1'b1;
            if (pr && k == 3) bus.rx_ready = 1'b0;
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        txq.push_back(b);
        mtx.push_back(b);
    endtask

    // tx feeder: offers queued beats whenever the holding register is empty.
    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        forever begin
            bit hs;
            @(negedge clk);
            hs = bus.tx_valid && bus.tx_ready && !rst;
            @(posedge clk);
            #2;
            if (hs) void'(txq.pop_front());
            if (txq.size() > 0) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = txq[0];
            end else begin
                bus.tx_valid = 1'b0;
            end
        end
    end

    // Compare process: every delivered rx beat, every frame_done, and pulse counts.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rx_valid && bus.rx_ready) begin
                    check("rx_beat_expected", exp_rx.size() > 0, 1'b1);
                    if (exp_rx.size() > 0) check("rx_data", bus.rx_data, exp_rx.pop_front());
                end
                if (bus.frame_done) begin
                    check("frame_done_expected", exp_fb.size() > 0, 1'b1);
                    if (exp_fb.size() > 0) check("frame_beats", bus.frame_beats, exp_fb.pop_front());
                end
                if (bus.tx_underrun) cnt_und++;
                if (bus.rx_overflow) cnt_ovf++;
            end
        end
    end

    // One frame as master. rst_after >= 0 pulses rst after that beat completes.
    task automatic frame(input bit pol, input bit pha, input logic [7:0] beats[$],
                         input int rst_after, input bit flip_pol, input bit pulse_rdy, input bit rdy);
        logic [7:0] ld[$];
        int n, nloads, idx;
        bit live;
        n      = beats.size();
        nloads = (rst_after >= 0) ? rst_after + 1 : n;
        for (int k = 0; k < nloads; k++) begin
            if (mtx.size() > 0) ld.push_back(mtx.pop_front());
            else begin
                ld.push_back(FILLV);
                exp_und++;
            end
        end
        for (int i = 0; i < nloads; i++) begin
            if (rdy || pulse_rdy || !m_slot_full) begin
                exp_rx.push_back(beats[i]);
                if (!rdy) m_slot_full = 1'b1;
            end else begin
                exp_ovf++;
            end
        end
        if (rst_after < 0) exp_fb.push_back((n > 255) ? 8'd255 : 8'(n));

        bus.cpol = pol;
        bus.cpha = pha;
        bus.SCLK = pol;
        tick(6);
        bus.CS = 1'b0;
        if (!pha) bus.MOSI = beats[0];
        tick(8);
        if (flip_pol) bus.cpol = ~pol;
        got_miso.delete();
        for (int i = 0; i < n; i++) begin
            live = (rst_after < 0) || (i <= rst_after);
            idx  = pha ? i : ((i == 0) ? 0 : i - 1);
            if (!pha) begin
                if (live) begin
                    got_miso.push_back(bus.MISO);
                    check("miso_beat", bus.MISO, ld[idx]);
                    check("miso_oe_active", bus.MISO_oe, 1'b1);
                end
                bus.SCLK = ~bus.SCLK;
                half(pulse_rdy);
                bus.SCLK = ~bus.SCLK;
                if (i + 1 < n) bus.MOSI = beats[i+1];
                half(1'b0);
            end else begin
                bus.SCLK = ~bus.SCLK;
                bus.MOSI = beats[i];
                half(1'b0);
                if (live) begin
                    got_miso.push_back(bus.MISO);
                    check("miso_beat", bus.MISO, ld[idx]);
                    check("miso_oe_active", bus.MISO_oe, 1'b1);
                end
                bus.SCLK = ~bus.SCLK;
                half(pulse_rdy);
            end
            if (i == rst_after) begin
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
                tick(1);
                check("oe_after_rst", bus.MISO_oe, 1'b0);
            end
        end
        bus.cpol = pol;
        tick(4);
        bus.CS = 1'b1;
        tick(8);
        check("miso_oe_idle", bus.MISO_oe, 1'b0);
        if (rst_after < 0) check("miso_after_frame", bus.MISO, ld[n-1]);
        else               check("miso_after_rst", bus.MISO, FILLV);
    endtask

    task automatic end_check();
        check("underrun_count", cnt_und, exp_und);
        check("overflow_count", cnt_ovf, exp_ovf);
        check("rx_all_delivered", exp_rx.size(), 0);
        check("frames_all_done", exp_fb.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        bus.SCLK = 1'b0;
        bus.CS   = 1'b1;
        bus.MOSI = '0;
        bus.cpol = 1'b0;
        bus.cpha = 1'b0;
        bus.rx_ready = 1'b1;
        tick(4);
        check("rst_miso", bus.MISO, FILLV);
        check("rst_oe", bus.MISO_oe, 1'b0);
        check("rst_rx_valid", bus.rx_valid, 1'b0);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_tx_ready", bus.tx_ready, 1'b1);
        check("rst_pulses", {bus.rx_overflow, bus.tx_underrun, bus.frame_done}, 3'b000);
        check("rst_frame_beats", bus.frame_beats, 8'h00);
        rst = 1'b0;
        tick(6);

        // Mode 0, one preloaded beat, then underrun.
        push_tx(8'hA5);
        tick(4);
        frame(1'b0, 1'b0, '{8'h3C, 8'h81}, -1, 1'b0, 1'b0, 1'b1);
        check("m0_first_miso", got_miso[0], 8'hA5);
        check("m0_end_miso", bus.MISO, 8'h00);
        check("m0_frame_beats", bus.frame_beats, 8'd2);
        check("m0_underruns", cnt_und, 1);
        end_check();

        // Mode 3, tx fed on demand.
        push_tx(8'h5A);
        push_tx(8'hC3);
        tick(4);
        frame(1'b1, 1'b1, '{8'h01, 8'h02}, -1, 1'b0, 1'b0, 1'b1);
        check("m3_miso0", got_miso[0], 8'h5A);
        check("m3_miso1", got_miso[1], 8'hC3);
        check("m3_no_new_underrun", cnt_und, 1);
        end_check();

        // Mode 1 then mode 2; cpol toggled while CS low must not matter.
        frame(1'b0, 1'b1, '{8'hF0}, -1, 1'b1, 1'b0, 1'b1);
        frame(1'b1, 1'b0, '{8'hF0}, -1, 1'b1, 1'b0, 1'b1);
        end_check();

        // Overflow: nothing consumed, two beats dropped.
        bus.rx_ready = 1'b0;
        frame(1'b0, 1'b0, '{8'h11, 8'h22, 8'h33}, -1, 1'b0, 1'b0, 1'b0);
        check("ovf_rx_data_held", bus.rx_data, 8'h11);
        check("ovf_rx_valid", bus.rx_valid, 1'b1);
        check("ovf_pulses", cnt_ovf, 2);
        bus.rx_ready = 1'b1;
        m_slot_full  = 1'b0;
        tick(4);
        end_check();

        // Consume in the same clk as a capture into a full slot.
        bus.rx_ready = 1'b0;
        frame(1'b0, 1'b0, '{8'h66}, -1, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, '{8'h77}, -1, 1'b0, 1'b1, 1'b0);
        check("same_clk_rx_data", bus.rx_data, 8'h77);
        check("same_clk_no_ovf", cnt_ovf, 2);
        bus.rx_ready = 1'b1;
        m_slot_full  = 1'b0;
        tick(4);
        end_check();

        // Reset in the middle of a frame, then a clean frame.
        frame(1'b0, 1'b0, '{8'hA1, 8'hB2, 8'hC3}, 0, 1'b0, 1'b0, 1'b1);
        check("midrst_rx_valid", bus.rx_valid, 1'b0);
        check("midrst_tx_ready", bus.tx_ready, 1'b1);
        check("midrst_frame_beats", bus.frame_beats, 8'h00);
        frame(1'b0, 1'b0, '{8'h44}, -1, 1'b0, 1'b0, 1'b1);
        check("post_rst_frame_beats", bus.frame_beats, 8'd1);
        end_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
